// File: rtl/cam_stream_gen.sv
// cam_stream_gen: OV7670-style camera stream generator.
// Produces CAM_pclk / CAM_vsync / CAM_href / CAM_px_data (RGB565, high byte
// first) with configurable geometry, blanking and pixel-clock ratio.
// Optional feature macro: CAM_GEN_GRADIENT_EN (gradient pattern on mode 2
// plus a 5-bit frame counter; when undefined mode 2 falls back to bars).
module cam_stream_gen #(
    parameter int TAM_LINE       = 320,
    parameter int TAM_ROW        = 120,
    parameter int BLACK_TAM_LINE = 4,
    parameter int BLACK_TAM_ROW  = 4,
    parameter int VSYNC_ROWS     = 2,
    parameter int PCLK_HALF      = 2,
    parameter int BAR_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done
);
    localparam int LINE_TOT = TAM_LINE + BLACK_TAM_LINE;
    localparam int ROW_TOT  = TAM_ROW + BLACK_TAM_ROW;
    localparam int LW       = (LINE_TOT > 1) ? $clog2(LINE_TOT) : 1;
    localparam int RW       = (ROW_TOT > 1) ? $clog2(ROW_TOT) : 1;
    localparam int DW       = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_TOT - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_TOT - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(PCLK_HALF - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Eight-entry colour-bar palette (RGB565)
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'h0000;
            3'd1:    bar_color = 16'hF800;
            3'd2:    bar_color = 16'h07E0;
            3'd3:    bar_color = 16'h001F;
            3'd4:    bar_color = 16'hFFE0;
            3'd5:    bar_color = 16'h07FF;
            3'd6:    bar_color = 16'hF81F;
            default: bar_color = 16'hFFFF;
        endcase
    endfunction

    logic [DW-1:0] div_cnt_reg;
    logic          pclk_reg;
    logic          div_tc;
    logic          tick;

    state_t        state_reg, state_next;
    logic [LW-1:0] line_cnt_reg, line_cnt_next;
    logic [RW-1:0] row_cnt_reg, row_cnt_next;
    logic [1:0]    mode_reg, mode_next;
    logic [15:0]   solid_reg, solid_next;
    logic          start_frame;
    logic          done_next;
`ifdef CAM_GEN_GRADIENT_EN
    logic [4:0]    frame_cnt_reg, frame_cnt_next;
`endif

    logic          vsync_reg, vsync_next;
    logic          href_reg, href_next;
    logic [7:0]    data_reg, data_next;
    logic          done_reg;
    logic [15:0]   px_next;
    logic [15:0]   pixel_next;

    assign div_tc = (div_cnt_reg == DIV_LAST);
    // A tick is the terminal-count cycle in which pclk falls, so stream
    // outputs are settled by the following pclk rising edge.
    assign tick   = div_tc & pclk_reg;

    // Free-running pclk divider
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            pclk_reg    <= 1'b0;
        end else if (div_tc) begin
            div_cnt_reg <= '0;
            pclk_reg    <= ~pclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Next position, pattern latches and frame-boundary decisions for a tick
    always_comb begin
        state_next    = state_reg;
        line_cnt_next = line_cnt_reg;
        row_cnt_next  = row_cnt_reg;
        mode_next     = mode_reg;
        solid_next    = solid_reg;
        start_frame   = 1'b0;
        done_next     = 1'b0;
`ifdef CAM_GEN_GRADIENT_EN
        frame_cnt_next = frame_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (en) begin
                    state_next  = S_RUN;
                    start_frame = 1'b1;
                end
            end
            default: begin
                if ((line_cnt_reg == LINE_LAST) && (row_cnt_reg == ROW_LAST)) begin
                    done_next = 1'b1;
`ifdef CAM_GEN_GRADIENT_EN
                    frame_cnt_next = frame_cnt_reg + 5'd1;
`endif
                    if (en) begin
                        start_frame = 1'b1;
                    end else begin
                        state_next    = S_IDLE;
                        line_cnt_next = '0;
                        row_cnt_next  = '0;
                    end
                end else if (line_cnt_reg == LINE_LAST) begin
                    line_cnt_next = '0;
                    row_cnt_next  = row_cnt_reg + 1'b1;
                end else begin
                    line_cnt_next = line_cnt_reg + 1'b1;
                end
            end
        endcase
        // Frame start: position (0,0) and a fresh copy of the pattern inputs
        if (start_frame) begin
            line_cnt_next = '0;
            row_cnt_next  = '0;
            mode_next     = mode;
            solid_next    = solid_color;
        end
    end

    // Sync and pixel byte for the position about to be driven
    always_comb begin
        px_next    = 16'(line_cnt_next >> 1);
        vsync_next = (state_next == S_RUN) && (32'(row_cnt_next) < VSYNC_ROWS);
        href_next  = (state_next == S_RUN) && (32'(row_cnt_next) >= BLACK_TAM_ROW)
                     && (32'(line_cnt_next) < TAM_LINE);
        case (mode_next)
            2'd1:    pixel_next = solid_next;
`ifdef CAM_GEN_GRADIENT_EN
            2'd2:    pixel_next = {px_next[4:0],
                                   6'(32'(row_cnt_next) - BLACK_TAM_ROW),
                                   frame_cnt_next};
`endif
            default: pixel_next = bar_color(3'(px_next / 16'(BAR_W)));
        endcase
        if (!href_next) begin
            data_next = 8'h00;
        end else if (line_cnt_next[0]) begin
            data_next = pixel_next[7:0];
        end else begin
            data_next = pixel_next[15:8];
        end
    end

    // State, counters and stream outputs; only ticks move them
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            line_cnt_reg <= '0;
            row_cnt_reg  <= '0;
            mode_reg     <= 2'd0;
            solid_reg    <= 16'h0000;
`ifdef CAM_GEN_GRADIENT_EN
            frame_cnt_reg <= 5'd0;
`endif
            vsync_reg    <= 1'b0;
            href_reg     <= 1'b0;
            data_reg     <= 8'h00;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= tick & done_next;
            if (tick) begin
                state_reg    <= state_next;
                line_cnt_reg <= line_cnt_next;
                row_cnt_reg  <= row_cnt_next;
                mode_reg     <= mode_next;
                solid_reg    <= solid_next;
`ifdef CAM_GEN_GRADIENT_EN
                frame_cnt_reg <= frame_cnt_next;
`endif
                vsync_reg    <= vsync_next;
                href_reg     <= href_next;
                data_reg     <= data_next;
            end
        end
    end

    assign CAM_pclk    = pclk_reg;
    assign CAM_vsync   = vsync_reg;
    assign CAM_href    = href_reg;
    assign CAM_px_data = data_reg;
    assign frame_done  = done_reg;

endmodule

// File: tb/tb_cam_stream_gen.sv
// tb_cam_stream_gen: directed + randomized bench for cam_stream_gen.
// A small-geometry instance is compared pclk by pclk against a position-index
// reference model; a default-parameter instance covers reset and divider.
`timescale 1ns/1ps
module tb_cam_stream_gen;
    localparam int TL = 16;
    localparam int TR = 4;
    localparam int BL = 4;
    localparam int BR = 4;
    localparam int VS = 2;
    localparam int BW = 2;
    localparam int LT = TL + BL;
    localparam int FP = LT * (TR + BR);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        en_def = 1'b0;
    logic [1:0]  mode_def = 2'd0;
    logic [15:0] solid_def = 16'h0000;

    logic        CAM_pclk, CAM_vsync, CAM_href, frame_done;
    logic [7:0]  CAM_px_data;
    logic        d_pclk, d_vsync, d_href, d_done;
    logic [7:0]  d_data;

    always #5 clk = ~clk;

    cam_stream_gen #(
        .TAM_LINE(TL), .TAM_ROW(TR), .BLACK_TAM_LINE(BL), .BLACK_TAM_ROW(BR),
        .VSYNC_ROWS(VS), .PCLK_HALF(1), .BAR_W(BW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_color(solid_color),
        .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
        .CAM_px_data(CAM_px_data), .frame_done(frame_done)
    );

    cam_stream_gen dut_def (
        .clk(clk), .rst(rst), .en(en_def), .mode(mode_def), .solid_color(solid_def),
        .CAM_pclk(d_pclk), .CAM_vsync(d_vsync), .CAM_href(d_href),
        .CAM_px_data(d_data), .frame_done(d_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: running flag, linear position index in the frame,
    // latched pattern inputs and frame number.
    bit          m_run = 1'b0;
    int          m_p = 0;
    int          m_fc = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [15:0] m_solid = 16'h0000;

    int tick_n = 0;
    int last_done = -1;
    int cnt_vs = 0;
    int cnt_hr = 0;
    int cnt_done = 0;

    logic [7:0] bar_row [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00,
                                 8'h07, 8'hE0, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h00, 8'h1F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_pixel(input int px, input int py,
                                              input logic [1:0] md, input logic [15:0] sc,
                                              input int fc);
        logic [15:0] pal [8];
        pal = '{16'h0000, 16'hF800, 16'h07E0, 16'h001F,
                16'hFFE0, 16'h07FF, 16'hF81F, 16'hFFFF};
        if (md == 2'd1) return sc;
`ifdef CAM_GEN_GRADIENT_EN
        if (md == 2'd2) return {5'(px), 6'(py), 5'(fc)};
`endif
        return pal[(px / BW) % 8];
    endfunction

    // Predict the next pclk slot from current inputs, wait until it has been
    // driven, then compare.
    task automatic tick_step();
        int row, line, n;
        logic [15:0] pxv;
        logic exp_vs, exp_hr, exp_dn;
        logic [7:0] exp_d;
        exp_dn = 1'b0;
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_p = 0; m_mode = mode; m_solid = solid_color;
            end
        end else if (m_p == FP - 1) begin
            exp_dn = 1'b1;
            m_fc = (m_fc + 1) % 32;
            if (en) begin
                m_p = 0; m_mode = mode; m_solid = solid_color;
            end else begin
                m_run = 1'b0;
            end
        end else begin
            m_p++;
        end
        row  = m_p / LT;
        line = m_p % LT;
        exp_vs = m_run && (row < VS);
        exp_hr = m_run && (row >= BR) && (line < TL);
        pxv = ref_pixel(line / 2, row - BR, m_mode, m_solid, m_fc);
        exp_d = !exp_hr ? 8'h00 : ((line % 2) == 0) ? pxv[15:8] : pxv[7:0];

        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (CAM_pclk === 1'b1) check("done_width", frame_done, 0);
        end while (CAM_pclk !== 1'b0 && n < 8);
        tick_n++;
        check("pclk_period", n, 2);
        check("vsync", CAM_vsync, exp_vs);
        check("href", CAM_href, exp_hr);
        check("data", CAM_px_data, exp_d);
        check("frame_done", frame_done, exp_dn);
        if (m_run && m_mode == 2'd0 && row == BR && line < TL)
            check("bar_row", CAM_px_data, bar_row[line]);
        if (m_run && m_mode == 2'd2 && m_fc == 1 && row == BR + 2 && (line == 6 || line == 7))
`ifdef CAM_GEN_GRADIENT_EN
            check("grad_px32", CAM_px_data, (line == 6) ? 8'h18 : 8'h41);
`else
            check("grad_px32", CAM_px_data, (line == 6) ? 8'hF8 : 8'h00);
`endif
        cnt_vs += int'(CAM_vsync === 1'b1);
        cnt_hr += int'(CAM_href === 1'b1);
        if (frame_done === 1'b1) begin
            cnt_done++;
            if (last_done >= 0) check("done_period", tick_n - last_done, FP);
            last_done = tick_n;
        end
        $display("t=%0t tick=%0d run=%0d pos=%0d vs=%0b hr=%0b data=%02h done=%0b",
                 $time, tick_n, m_run, m_p, CAM_vsync, CAM_href, CAM_px_data, frame_done);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick_step();
    endtask

    initial begin
        // Reset held 5 clk
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_main", {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done}, 0);
        check("rst_def", {d_pclk, d_vsync, d_href, d_data, d_done}, 0);

        // Release with en = 0: divider runs, stream stays quiet
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("def_pclk", d_pclk, (k / 2) % 2);
            check("def_idle", {d_vsync, d_href, d_data, d_done}, 0);
            check("main_pclk", CAM_pclk, k % 2);
            check("main_idle", {CAM_vsync, CAM_href, CAM_px_data, frame_done}, 0);
            $display("t=%0t divider k=%0d def_pclk=%0b main_pclk=%0b", $time, k, d_pclk, CAM_pclk);
        end

        run_ticks(3);

        // Frame 0: bars; mode/solid changed mid-frame must not take effect
        en = 1'b1; mode = 2'd0; solid_color = 16'($urandom);
        cnt_vs = 0; cnt_hr = 0;
        run_ticks(81);
        mode = 2'd2; solid_color = 16'($urandom);
        run_ticks(79);
        check("frame_vsync_cnt", cnt_vs, 40);
        check("frame_href_cnt", cnt_hr, 64);

        // Frame 1: gradient (or bars without the macro)
        run_ticks(160);

        // Frame 2: solid A5C3, new colour mid-frame applies from frame 3
        mode = 2'd1; solid_color = 16'hA5C3;
        run_ticks(80);
        solid_color = 16'($urandom);
        run_ticks(81);

        // Frame 3: drop en at row 5, frame still completes
        run_ticks(100);
        en = 1'b0; cnt_done = 0;
        run_ticks(60);
        run_ticks(10);
        check("drop_done_cnt", cnt_done, 1);
        check("idle_vsync", CAM_vsync, 0);

        // Frame 4: bars via mode 3, reset mid-row
        en = 1'b1; mode = 2'd3; solid_color = 16'($urandom);
        run_ticks(108);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done}, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_hold", {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done}, 0);
        end
        $display("t=%0t mid-frame reset applied", $time);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_stream_gen.md
# cam_stream_gen

Parametrised OV7670-style camera stream generator for simulation and on-board self-test of the capture and VGA path. It produces `CAM_pclk`, `CAM_vsync`, `CAM_href` and `CAM_px_data` with configurable frame geometry, blanking and pixel-clock ratio. It emits RGB565 pixels, high byte first, in one of several pattern modes. It drives the `CAM_*` inputs of `test_cam` in place of an external sensor.

## Interface
- `TAM_LINE`, 320: active bytes per line (2 bytes per pixel; must be even).
- `TAM_ROW`, 120: active rows per frame.
- `BLACK_TAM_LINE`, 4: blanking bytes appended after each line.
- `BLACK_TAM_ROW`, 4: blanking rows at frame start.
- `VSYNC_ROWS`, 2: rows with vsync high, starting at row 0; must be ≤ `BLACK_TAM_ROW`.
- `PCLK_HALF`, 2: clk cycles per pclk half-period; must be ≥ 1.
- `BAR_W`, 20: pixels per colour bar.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  generator enable, sampled at frame boundary.
- `mode`  in  2  pattern: 0 = bars, 1 = solid, 2 = gradient, 3 = bars; sampled at frame boundary.
- `solid_color`  in  16  RGB565 value used in mode 1; sampled at frame boundary.
- `CAM_pclk`  out  1  generated pixel clock, registered.
- `CAM_vsync`  out  1  frame sync, active high.
- `CAM_href`  out  1  line valid, active high.
- `CAM_px_data`  out  8  pixel byte.
- `frame_done`  out  1  one-clk pulse at the end of each frame.

## Operation
- **Divider:** `div_cnt` counts 0..`PCLK_HALF`-1. At terminal count, `CAM_pclk` toggles. A *tick* is the terminal-count cycle in which `CAM_pclk` goes 1→0. All stream outputs update only on ticks, so they are stable at the pclk rising edge. pclk free-runs whenever `rst` = 0, including while idle.
- **State machine:** IDLE and RUN.
  - IDLE: vsync, href and data are 0. On a tick with `en` = 1, go to RUN: latch `mode` and `solid_color`, set `line_cnt` = `row_cnt` = 0, and drive the first position's outputs on that same tick.
  - RUN: each tick advances `line_cnt` from 0 to `TAM_LINE`+`BLACK_TAM_LINE`-1, then wraps to 0 and increments `row_cnt`. `row_cnt` runs from 0 to `TAM_ROW`+`BLACK_TAM_ROW`-1.
  - On the tick after the last position, pulse `frame_done` and increment `frame_cnt` (5-bit, wraps). Then, if `en` = 1, stay in RUN from (0,0) and re-latch `mode`/`solid_color`; otherwise go to IDLE.
  - Dropping `en` mid-frame has no effect until the frame completes.
- **Sync outputs** (functions of the position being driven):
  - vsync = `row_cnt` < `VSYNC_ROWS`.
  - href = (`row_cnt` ≥ `BLACK_TAM_ROW`) and (`line_cnt` < `TAM_LINE`).
- **Pixel coordinates:** px = `line_cnt`>>1, py = `row_cnt`-`BLACK_TAM_ROW`. Even `line_cnt` outputs pixel[15:8]; odd outputs pixel[7:0]. Data is 8'h00 whenever href = 0.
- **Bars:** palette index = (px / `BAR_W`) mod 8. Palette: 0000, F800, 07E0, 001F, FFE0, 07FF, F81F, FFFF.
- **Solid:** pixel = latched `solid_color`.
- **Gradient:** pixel = {px[4:0], py[5:0], frame_cnt[4:0]}.
- **Counter widths:** `$clog2` of the range, minimum 1 bit.

## Timing
- **Reset values:** `CAM_pclk` = 0, `CAM_vsync` = 0, `CAM_href` = 0, `CAM_px_data` = 0, `frame_done` = 0. State = IDLE, all counters = 0. Reset wins over every other event in the same cycle.
- **Reset mid-frame:** all outputs return to reset values on the next edge. No partial `frame_done` is emitted.
- **Output changes:** registered, one clk after the tick condition is evaluated. Outputs never change on non-tick cycles.
- **`frame_done`:** high for exactly one clk, coincident with the tick that drives position (0,0) of the next frame or the first IDLE tick.
- **Line period:** (`TAM_LINE`+`BLACK_TAM_LINE`)·2·`PCLK_HALF` clk cycles.
- **Frame period:** line period × (`TAM_ROW`+`BLACK_TAM_ROW`).

## Configuration
- `CAM_GEN_GRADIENT_EN`
  - Defined: mode 2 produces the gradient, and `frame_cnt` is implemented.
  - Undefined: mode 2 behaves as bars, and `frame_cnt` with its logic is removed.
  - Modes 0, 1 and 3 are identical in both builds.

## Test plan
- **Reset and divider:** defaults, `rst` held 5 clk → all outputs 0. Release `rst` with `en` = 0 → `CAM_pclk` period is 4 clk; vsync, href and data stay 0.
- **Frame geometry:** `TAM_LINE`=16, `TAM_ROW`=4, `BLACK_TAM_LINE`=4, `BLACK_TAM_ROW`=4, `VSYNC_ROWS`=2, `PCLK_HALF`=1, `en`=1.
  - Vsync high for 40 pclk.
  - Each active row has href high for exactly 16 pclk, then 4 low.
  - `frame_done` every 160 pclk.
- **Bars:** `BAR_W`=2, mode 0, first active row bytes → 00,00,00,00,F8,00,F8,00,07,E0,07,E0,00,1F,00,1F.
- **Solid and frame-boundary latch:** mode 1, `solid_color`=16'hA5C3 → bytes alternate A5,C3. Changing `solid_color` mid-frame takes effect only after the next `frame_done`.
- **Enable drop and mid-frame reset:**
  - Deassert `en` at row 5 → frame completes, one `frame_done`, then IDLE with vsync = 0.
  - Assert `rst` mid-row → all outputs 0 the next clk, and no `frame_done`.
- **Gradient (build with `CAM_GEN_GRADIENT_EN`):**
  - Mode 2: pixel (3,2) in frame 1 = 16'h1841.
  - Build without the macro: same stimulus yields bar data.
